// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small byte FIFO on a valid/ready input.
// Bits are paced by a free-running baud counter that only runs outside IDLE.
module uart_tx #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       UART_TX,
  output logic       busy
);

  localparam int unsigned BIT_CYC = CLK_FREQ / BAUD;
  localparam int unsigned CW      = $clog2(BIT_CYC + 1);
  localparam int unsigned AW      = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q, state_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW:0]     wptr_q, rptr_q;
  logic            full, empty, push, pop;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            bit_tick;
  logic [7:0]      shreg_q, shreg_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic            line_q, line_d;
  logic [7:0]      head;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty = (wptr_q == rptr_q);
  assign push  = tx_valid && !full;
  assign head  = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q[AW-1:0]] <= tx_data;
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    bit_tick = 1'b0;
    if (state_q == StIdle) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(BIT_CYC - 1)) begin
      bit_tick = 1'b1;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      line_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      line_q   <= line_d;
      if (push) begin
        wptr_q <= wptr_q + (AW + 1)'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + (AW + 1)'(1);
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!empty) state_d = StStart;
      StStart: if (bit_tick) state_d = StData;
      StData:  if (bit_tick && (bitcnt_q == 3'd7)) state_d = StStop;
      StStop: begin
        if (bit_tick) state_d = empty ? StIdle : StStart;
      end
    endcase
  end

  // Outputs and datapath next values
  always_comb begin
    pop      = 1'b0;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    line_d   = line_q;
    tx_ready = !full;
    busy     = (state_q != StIdle) || !empty;
    unique case (state_q)
      StIdle: begin
        line_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shreg_d = head;
          line_d  = 1'b0;
        end
      end
      StStart: begin
        if (bit_tick) begin
          line_d   = shreg_q[0];
          bitcnt_d = '0;
        end
      end
      StData: begin
        if (bit_tick) begin
          if (bitcnt_q == 3'd7) begin
            line_d = 1'b1;
          end else begin
            shreg_d  = shreg_q >> 1;
            line_d   = shreg_q[1];
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end
      end
      StStop: begin
        if (bit_tick) begin
          if (!empty) begin
            pop     = 1'b1;
            shreg_d = head;
            line_d  = 1'b0;
          end else begin
            line_d = 1'b1;
          end
        end
      end
    endcase
  end

  assign UART_TX = line_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: frame-position reference model checked every cycle,
// a table of single-byte frames, and directed burst/full/reset sequences.
module tb_uart_tx;

  localparam int unsigned BC    = 10;
  localparam int unsigned DEPTH = 4;
  localparam int          D_BIT = 5208;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, line, busy;
  logic [7:0] d_data = 8'h00;
  logic       d_valid = 1'b0;
  logic       d_ready, d_line, d_busy;

  uart_tx #(.CLK_FREQ(100), .BAUD(10), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .UART_TX  (line),
    .busy     (busy)
  );

  uart_tx u_def (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_data  (d_data),
    .tx_valid (d_valid),
    .tx_ready (d_ready),
    .UART_TX  (d_line),
    .busy     (d_busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of waiting bytes plus the clock position inside the current frame.
  logic [7:0] m_q[$];
  logic       m_active = 1'b0;
  int         m_pos = 0;
  logic [7:0] m_cur = 8'h00;

  task automatic model_step();
    bit rdy;
    rdy = (m_q.size() < DEPTH);
    if (m_active) begin
      if (m_pos == 10 * BC - 1) begin
        if (m_q.size() > 0) begin
          m_cur = m_q.pop_front();
          m_pos = 0;
        end else begin
          m_active = 1'b0;
        end
      end else begin
        m_pos++;
      end
    end else if (m_q.size() > 0) begin
      m_cur    = m_q.pop_front();
      m_active = 1'b1;
      m_pos    = 0;
    end
    if (tx_valid && rdy) m_q.push_back(tx_data);
  endtask

  function automatic logic exp_line();
    int k;
    if (!m_active) return 1'b1;
    k = m_pos / BC;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_cur[k-1];
    return 1'b1;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_q.delete();
        m_active = 1'b0;
        m_pos    = 0;
      end else begin
        model_step();
      end
      #1;
      check("mdl_line", line, exp_line());
      check("mdl_ready", tx_ready, (m_q.size() < DEPTH));
      check("mdl_busy", busy, (m_active || m_q.size() > 0));
    end
  end

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy !== 1'b0 && n < max_cyc);
    check("idle_reached", busy, 1'b0);
  endtask

  task automatic rx_frame(output logic [7:0] b, output int t_start);
    int n = 0;
    b = 8'h00;
    do begin
      @(negedge clk);
      n++;
    end while (line !== 1'b0 && n < 400);
    check("rx_start_found", (n < 400), 1'b1);
    t_start = cyc;
    repeat (5) @(negedge clk);
    check("rx_start_bit", line, 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (10) @(negedge clk);
      b[i] = line;
    end
    repeat (10) @(negedge clk);
    check("rx_stop_bit", line, 1'b1);
  endtask

  task automatic rx_n(input int cnt, input logic [7:0] exp_b [6]);
    logic [7:0] b;
    int t, t_prev;
    t_prev = 0;
    for (int i = 0; i < cnt; i++) begin
      rx_frame(b, t);
      check($sformatf("rx_byte%0d", i), b, exp_b[i]);
      if (i > 0) check($sformatf("rx_gap%0d", i), t - t_prev, 10 * BC);
      t_prev = t;
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] bits;  // bits[0] is the first sample (start bit)
  } vec_t;

  vec_t       vecs[5];
  logic [7:0] exp_b[6];
  logic [9:0] samp;
  int         lows;
  int         n, k, t0;
  logic       last;
  int         offs[5];
  int         exp_offs[5];

  initial begin
    vecs[0] = '{8'hA5, 10'b1_1010_0101_0};
    vecs[1] = '{8'h00, 10'b1_0000_0000_0};
    vecs[2] = '{8'hFF, 10'b1_1111_1111_0};
    vecs[3] = '{8'h3C, 10'b1_0011_1100_0};
    vecs[4] = '{8'h81, 10'b1_1000_0001_0};

    // Reset state
    @(negedge clk);
    check("rst_line", line, 1'b1);
    check("rst_ready", tx_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_def_line", d_line, 1'b1);
    check("rst_def_ready", d_ready, 1'b1);
    rst_n = 1'b1;
    lows = 0;
    repeat (50) begin
      @(negedge clk);
      if (line !== 1'b1) lows++;
    end
    check("idle_after_reset", lows, 0);

    // Single-byte frames from the table
    for (int v = 0; v < 5; v++) begin
      tx_data  = vecs[v].data;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      check("pre_start_line", line, 1'b1);
      @(negedge clk);
      check("start_fall", line, 1'b0);
      repeat (5) @(negedge clk);
      samp[0] = line;
      for (int i = 1; i < 10; i++) begin
        repeat (10) @(negedge clk);
        samp[i] = line;
      end
      check($sformatf("frame_%0h", vecs[v].data), samp, vecs[v].bits);
      repeat (4) @(negedge clk);
      check("busy_in_stop", busy, 1'b1);
      @(negedge clk);
      check("busy_drop", busy, 1'b0);
      check("line_idle", line, 1'b1);
      @(negedge clk);
    end

    // Burst of five plus one refused write
    exp_b = '{8'h00, 8'hFF, 8'h55, 8'h3C, 8'h81, 8'h00};
    fork
      rx_n(5, exp_b);
      begin
        for (int i = 0; i < 5; i++) begin
          check("burst_ready", tx_ready, 1'b1);
          tx_data  = exp_b[i];
          tx_valid = 1'b1;
          @(negedge clk);
        end
        tx_data = 8'hEE;
        check("burst_full", tx_ready, 1'b0);
        @(negedge clk);
        tx_valid = 1'b0;
        check("burst_refused", tx_ready, 1'b0);
      end
    join
    wait_idle(200);

    // Write attempted on the pop edge while full
    exp_b = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'h99};
    fork
      rx_n(6, exp_b);
      begin
        for (int i = 0; i < 5; i++) begin
          tx_data  = exp_b[i];
          tx_valid = 1'b1;
          @(negedge clk);
        end
        tx_valid = 1'b0;
        repeat (96) @(negedge clk);
        tx_data  = 8'h99;
        tx_valid = 1'b1;
        check("pop_edge_ready", tx_ready, 1'b0);
        @(negedge clk);
        check("after_pop_ready", tx_ready, 1'b1);
        @(negedge clk);
        tx_valid = 1'b0;
        check("refilled_full", tx_ready, 1'b0);
      end
    join
    wait_idle(200);

    // Reset during data bit 4 of 0x0F with two bytes queued
    tx_data = 8'h0F; tx_valid = 1'b1;
    @(negedge clk);
    tx_data = 8'h11;
    @(negedge clk);
    tx_data = 8'h22;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (53) @(negedge clk);
    check("bit4_low", line, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_line", line, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_ready", tx_ready, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    repeat (150) begin
      @(negedge clk);
      if (line !== 1'b1 || busy !== 1'b0) lows++;
    end
    check("no_resume", lows, 0);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      tx_valid = ($urandom_range(0, 19) == 0);
      tx_data  = 8'($urandom);
    end
    @(negedge clk);
    tx_valid = 1'b0;
    wait_idle(800);

    // Default parameters, byte 0x41
    exp_offs = '{D_BIT, 2 * D_BIT, 7 * D_BIT, 8 * D_BIT, 9 * D_BIT};
    d_data  = 8'h41;
    d_valid = 1'b1;
    @(negedge clk);
    d_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (d_line !== 1'b0 && n < 10);
    check("def_start", n, 1);
    t0 = cyc;
    last = 1'b0;
    k = 0;
    n = 0;
    while (n < 60000 && d_busy === 1'b1) begin
      @(negedge clk);
      n++;
      if (d_line !== last) begin
        if (k < 5) offs[k] = cyc - t0;
        k++;
        last = d_line;
      end
    end
    check("def_edges", k, 5);
    for (int i = 0; i < 5; i++) check($sformatf("def_edge%0d", i), offs[i], exp_offs[i]);
    check("def_frame_len", cyc - t0, 10 * D_BIT);
    check("def_line_end", d_line, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
